tick_gen_multi: RTL and testbench
=================================

// Module: tick_gen_multi
// PURPOSE
//   Parametrised multi-channel tick generator; successor to the fixed 128 Hz / 1 Hz divider.
//   A base prescaler divides clk into base_tick. NUM_CH channels each divide base_tick by a
//   run-time divisor. Each channel runs periodic or one-shot. Feeds display refresh, game timers
//   and countdowns. All outputs are single-clk enable pulses, never used as clocks.
// PARAMETERS
//   BASE_DIV  390625  clk cycles per base tick (exact period); 100 MHz -> 256 Hz; must be >= 2
//   BASE_W    21      base counter width; 2**BASE_W >= BASE_DIV
//   NUM_CH    2       number of channels, >= 1
//   CNT_W     8       channel counter / divisor width
// PORTS
//   clk        in   1             system clock, 100 MHz
//   rst_n      in   1             asynchronous active-low reset
//   run        in   1             1 = count; 0 = freeze all counters (pause)
//   clear      in   1             synchronous clear of all counters and done flags
//   ch_en      in   NUM_CH        per-channel enable
//   ch_oneshot in   NUM_CH        1 = stop after first tick; 0 = periodic
//   ch_div     in   NUM_CH*CNT_W  divisor in base ticks; ch i = [i*CNT_W +: CNT_W]
//   base_tick  out  1             1-clk pulse per base period
//   ch_tick    out  NUM_CH        1-clk pulse per channel period
//   ch_done    out  NUM_CH        sticky: one-shot channel has fired
//   ch_count   out  NUM_CH*CNT_W  current channel count, same packing as ch_div
// BEHAVIOUR
//   Reset (rst_n=0, async): base_cnt=0; all channel counts=0; all outputs 0.
//   Priority per cycle: clear > run=0 > normal count.
//   base_hit = run & ~clear & (base_cnt == BASE_DIV-1).
//     On base_hit base_cnt wraps to 0; otherwise base_cnt+1 when run.
//   base_tick is registered: high for exactly the cycle after base_hit.
//     In steady run the period is exactly BASE_DIV clks.
//   Channel i updates only on base_hit, with d = ch_div[i]:
//   - ~ch_en[i]: count<=0, done<=0, no tick; applies on every cycle, not just base_hit.
//   - d==0: channel inert; count held at 0, no tick.
//   - done[i]=1 (one-shot fired): count held at 0, no further ticks.
//   - count >= d-1: count<=0; ch_tick[i] pulses in the same cycle as base_tick.
//     If ch_oneshot[i]=1, done[i]<=1 in that cycle.
//   - otherwise: count<=count+1.
//   The compare is >=, so lowering d below the current count wraps at the next base_hit; no runaway.
//   d==1 ticks on every base_tick. The channel period is d*BASE_DIV clks.
//   Arithmetic: d-1 is evaluated in CNT_W bits, only when d!=0. Counts never exceed 2**CNT_W-1.
//   run=0: base_cnt and counts hold; base_tick and ch_tick are 0 from the next cycle. Resuming
//     continues mid-period, with no phase loss.
//   clear=1: base_cnt, counts and done go to 0; ticks are 0 next cycle. Clear wins over a
//     coincident base_hit. The first base_tick after clear falls BASE_DIV clks after clear drops.
//   ch_oneshot toggled while done=1: done holds until clear or ~ch_en.
//   ch_en rising mid-period: the channel starts from 0 at the next base_hit. Channels are not
//     phase-aligned to each other.
//   rst_n asserted mid-operation: immediate zeroing. Pulses in flight are dropped. Deassertion
//     is synchronous to clk upstream.
// TESTING (bench uses BASE_DIV=4, NUM_CH=2, CNT_W=8)
//   1) rst_n=0 mid-count -> all outputs 0 immediately. Release, run=1, ch_en=0 -> base_tick
//      every 4 clks, first base_tick 4 clks after run, ch_tick=0.
//   2) ch_div={3,1}, ch_en=11 -> ch1 ticks with every base_tick; ch0 ticks every 12 clks,
//      coincident with every 3rd base_tick.
//   3) run=0 for 10 clks when ch0 count=1 and base_cnt=2 -> no ticks, counts frozen. After
//      run=1, next base_tick is 2 clks later; ch0 ticks on the 2nd base_tick after resume.
//   4) ch0 oneshot, div=2 -> single ch_tick at 8 clks; ch_done=1 stays set, count held 0.
//      clear=1 -> done=0 and a new cycle starts.
//   5) ch0 div=10 with count=7, then div=3 -> tick at next base_hit, count 0. Set div=0 ->
//      count 0, no ticks.
//   6) clear=1 in the same cycle as base_hit -> no base_tick, no ch_tick. All counts 0; next
//      base_tick comes 4 clks after clear drops.

Source files
------------

// File: rtl/tick_gen_multi_if.sv
// Control/status bundle for tick_gen_multi.
//   run, clear            : global pause / synchronous clear
//   ch_en, ch_oneshot     : per-channel enable and one-shot select
//   ch_div                : per-channel divisor, ch i at [i*CNT_W +: CNT_W]
//   base_tick, ch_tick    : single-clk enable pulses
//   ch_done, ch_count     : sticky one-shot flags and live channel counts
interface tick_gen_multi_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  logic                    run;
  logic                    clear;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       ch_oneshot;
  logic [NUM_CH*CNT_W-1:0] ch_div;
  logic                    base_tick;
  logic [NUM_CH-1:0]       ch_tick;
  logic [NUM_CH-1:0]       ch_done;
  logic [NUM_CH*CNT_W-1:0] ch_count;

  modport master (
    output run, clear, ch_en, ch_oneshot, ch_div,
    input  base_tick, ch_tick, ch_done, ch_count
  );

  modport slave (
    input  run, clear, ch_en, ch_oneshot, ch_div,
    output base_tick, ch_tick, ch_done, ch_count
  );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator.
// A base prescaler divides clk by BASE_DIV into base_tick; each of NUM_CH channels divides
// base_tick by its run-time divisor, periodic or one-shot. All outputs are 1-clk enables.
// Ports: clk, rst_n (async active-low), bus (tick_gen_multi_if.slave).

// One channel: counts base hits, wraps at div-1 and emits a tick aligned with base_tick.
module tick_gen_ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             base_hit,
  input  logic             en,
  input  logic             oneshot,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             done,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] div_m1;

  // Only consulted when div != 0, so the wrap of 0-1 never matters.
  assign div_m1 = div - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b0;
      tick  <= 1'b0;
    end else if (clear || !en) begin
      count <= '0;
      done  <= 1'b0;
      tick  <= 1'b0;
    end else if (base_hit) begin
      if (div == '0 || done) begin
        count <= '0;
        tick  <= 1'b0;
      end else if (count >= div_m1) begin
        // >= so a divisor lowered below the live count wraps at once.
        count <= '0;
        tick  <= 1'b1;
        if (oneshot) done <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end
endmodule

module tick_gen_multi #(
  parameter int BASE_DIV = 390625,
  parameter int BASE_W   = 21,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  tick_gen_multi_if.slave bus
);
  localparam logic [BASE_W-1:0] BASE_MAX = BASE_W'(BASE_DIV - 1);

  logic [BASE_W-1:0]            base_cnt;
  logic                         base_hit;
  logic                         base_tick_q;
  logic [NUM_CH-1:0]            tick_q;
  logic [NUM_CH-1:0]            done_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_CH-1:0][CNT_W-1:0] div_v;

  // clear outranks run, which outranks counting; a coincident clear suppresses the hit.
  assign base_hit = bus.run & ~bus.clear & (base_cnt == BASE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_cnt    <= '0;
      base_tick_q <= 1'b0;
    end else begin
      base_tick_q <= base_hit;
      if (bus.clear)    base_cnt <= '0;
      else if (base_hit) base_cnt <= '0;
      else if (bus.run)  base_cnt <= base_cnt + BASE_W'(1);
    end
  end

  assign div_v = bus.ch_div;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_gen_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bus.clear),
      .base_hit (base_hit),
      .en       (bus.ch_en[i]),
      .oneshot  (bus.ch_oneshot[i]),
      .div      (div_v[i]),
      .tick     (tick_q[i]),
      .done     (done_q[i]),
      .count    (cnt_q[i])
    );
  end

  assign bus.base_tick = base_tick_q;
  assign bus.ch_tick   = tick_q;
  assign bus.ch_done   = done_q;
  assign bus.ch_count  = cnt_q;
endmodule

// File: tb/tb_tick_gen_multi.sv
module tb_tick_gen_multi;
  localparam int BASE_DIV = 4;
  localparam int BASE_W   = 3;
  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  tick_gen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  tick_gen_multi #(
    .BASE_DIV (BASE_DIV),
    .BASE_W   (BASE_W),
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: phase within base period, base ticks elapsed in each channel's period.
  int m_phase;
  int m_elapsed [NUM_CH];
  bit m_fired   [NUM_CH];
  bit m_btick;
  bit m_ctick   [NUM_CH];

  function automatic int div_of(int i);
    logic [NUM_CH*CNT_W-1:0] v;
    v = bus.ch_div;
    return int'(v[i*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_btick = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_elapsed[i] = 0; m_fired[i] = 0; m_ctick[i] = 0;
    end
  endtask

  // Applies one clock edge of the specified behaviour using the inputs seen at that edge.
  task automatic model_edge();
    bit hit;
    int d;
    if (!rst_n) begin model_reset(); return; end
    hit = bus.run && !bus.clear && (m_phase == BASE_DIV - 1);
    if (bus.clear) m_phase = 0;
    else if (bus.run) m_phase = (m_phase + 1) % BASE_DIV;
    m_btick = hit;
    for (int i = 0; i < NUM_CH; i++) begin
      d = div_of(i);
      m_ctick[i] = 0;
      if (bus.clear || !bus.ch_en[i]) begin
        m_elapsed[i] = 0; m_fired[i] = 0;
      end else if (hit) begin
        if (d == 0 || m_fired[i]) m_elapsed[i] = 0;
        else if (m_elapsed[i] + 1 >= d) begin
          m_elapsed[i] = 0;
          m_ctick[i] = 1;
          if (bus.ch_oneshot[i]) m_fired[i] = 1;
        end else m_elapsed[i]++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH*CNT_W-1:0] cv;
    cv = bus.ch_count;
    chk("base_tick", 32'(bus.base_tick), 32'(m_btick));
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("ch_tick[%0d]", i),  32'(bus.ch_tick[i]), 32'(m_ctick[i]));
      chk($sformatf("ch_done[%0d]", i),  32'(bus.ch_done[i]), 32'(m_fired[i]));
      chk($sformatf("ch_count[%0d]", i), 32'(cv[i*CNT_W +: CNT_W]), 32'(m_elapsed[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Steps until base_tick is seen; returns clocks taken, or flags a timeout.
  task automatic clks_to_base(output int n);
    n = 0;
    do begin step(); n++; end while (!bus.base_tick && n < 50);
    if (!bus.base_tick) chk("base_tick_timeout", 0, 1);
  endtask

  task automatic clks_to_ch0(output int n);
    n = 0;
    do begin step(); n++; end while (!bus.ch_tick[0] && n < 100);
    if (!bus.ch_tick[0]) chk("ch_tick_timeout", 0, 1);
  endtask

  initial begin
    int n;
    logic [NUM_CH*CNT_W-1:0] dv;
    rst_n = 1'b0;
    bus.run = 0; bus.clear = 0; bus.ch_en = '0; bus.ch_oneshot = '0; bus.ch_div = '0;
    model_reset();
    repeat (2) step();

    // 1) base tick alone, then async reset mid-count
    rst_n = 1'b1;
    bus.run = 1;
    clks_to_base(n);
    chk("first_base_tick_clks", 32'(n), 32'(4));
    clks_to_base(n);
    chk("base_period", 32'(n), 32'(4));
    step(); step();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    clks_to_base(n);
    chk("base_after_reset", 32'(n), 32'(4));

    // 2) ch1 div 1, ch0 div 3
    dv = '0; dv[0 +: CNT_W] = 8'd3; dv[CNT_W +: CNT_W] = 8'd1;
    bus.ch_div = dv; bus.ch_en = 2'b11;
    clks_to_ch0(n);
    clks_to_ch0(n);
    chk("ch0_period", 32'(n), 32'(12));
    repeat (24) step();

    // 3) pause with ch0 count 1 and base phase 2
    n = 0;
    while (!(m_phase == 2 && m_elapsed[0] == 1) && n < 60) begin step(); n++; end
    chk("pause_setup", 32'(m_phase == 2 && m_elapsed[0] == 1), 32'(1));
    bus.run = 0;
    repeat (10) step();
    chk("paused_count", 32'(bus.ch_count[0 +: CNT_W]), 32'(1));
    bus.run = 1;
    clks_to_base(n);
    chk("resume_base_clks", 32'(n), 32'(2));
    chk("resume_ch0_quiet", 32'(bus.ch_tick[0]), 32'(0));
    clks_to_base(n);
    chk("resume_ch0_tick", 32'(bus.ch_tick[0]), 32'(1));

    // 4) one-shot div 2
    bus.clear = 1; bus.ch_oneshot = 2'b01; dv[0 +: CNT_W] = 8'd2; bus.ch_div = dv;
    step();
    bus.clear = 0;
    clks_to_ch0(n);
    chk("oneshot_clks", 32'(n), 32'(8));
    repeat (20) step();
    chk("oneshot_done", 32'(bus.ch_done[0]), 32'(1));
    bus.ch_oneshot = 2'b00;
    repeat (8) step();
    bus.clear = 1;
    step();
    chk("done_cleared", 32'(bus.ch_done[0]), 32'(0));
    bus.clear = 0;
    repeat (12) step();

    // 5) lower divisor below live count, then divisor 0
    dv[0 +: CNT_W] = 8'd10; bus.ch_div = dv;
    n = 0;
    while (!(m_elapsed[0] == 7) && n < 80) begin step(); n++; end
    chk("div10_count7", 32'(bus.ch_count[0 +: CNT_W]), 32'(7));
    dv[0 +: CNT_W] = 8'd3; bus.ch_div = dv;
    clks_to_base(n);
    chk("lowered_div_tick", 32'(bus.ch_tick[0]), 32'(1));
    dv[0 +: CNT_W] = 8'd0; bus.ch_div = dv;
    repeat (16) step();

    // 6) clear coincident with base hit
    dv[0 +: CNT_W] = 8'd2; bus.ch_div = dv;
    n = 0;
    while (m_phase != BASE_DIV - 1 && n < 10) begin step(); n++; end
    bus.clear = 1;
    step();
    chk("clear_hit_no_base", 32'(bus.base_tick), 32'(0));
    chk("clear_hit_no_ch", 32'(bus.ch_tick), 32'(0));
    bus.clear = 0;
    clks_to_base(n);
    chk("base_after_clear", 32'(n), 32'(4));

    // Randomised traffic against the reference
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) bus.run = ($urandom_range(0, 3) != 0);
      bus.clear = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 20) == 0) bus.ch_en = 2'($urandom);
      if ($urandom_range(0, 20) == 0) bus.ch_oneshot = 2'($urandom);
      if ($urandom_range(0, 25) == 0) begin
        dv[0 +: CNT_W] = 8'($urandom_range(0, 5));
        dv[CNT_W +: CNT_W] = 8'($urandom_range(0, 5));
        bus.ch_div = dv;
      end
      if ($urandom_range(0, 400) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
